bit32_serial_adder: RTL and testbench

//  Multi-cycle two's-complement adder for the ALU datapath. It adds one SLICE-bit

---
 rtl/bit32_serial_adder.sv | 166 ++++++++++++++++
 tb/tb_bit32_serial_adder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bit32_serial_adder.sv
// Multi-cycle adder that adds one SLICE-bit slice per clock, LSB slice first, with valid/ready handshakes.
// Optional feature macro: SERIAL_ADDER_OVF_EN enables the signed-overflow output.
module bit32_serial_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NSL  = WIDTH / SLICE;
    localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSL - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cin_q, cin_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [SLICE-1:0]  a_slice_s;
    logic [SLICE-1:0]  b_slice_s;
    logic              carry_in_s;
    logic [SLICE:0]    slice_sum_s;

    // Slice datapath: slice 0 takes the latched cin, later slices take the carry register
    always_comb begin
        a_slice_s   = a_q[idx_q*SLICE +: SLICE];
        b_slice_s   = b_q[idx_q*SLICE +: SLICE];
        carry_in_s  = (idx_q == {IDXW{1'b0}}) ? cin_q : carry_q;
        slice_sum_s = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{SLICE{1'b0}}, carry_in_s};
    end

    // Next-state and next-output logic for the handshake FSM
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cin_d       = cin_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    cin_d      = cin;
                    carry_d    = 1'b0;
                    idx_d      = {IDXW{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = ST_CALC;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_CALC: begin
                s_d[idx_q*SLICE +: SLICE] = slice_sum_s[SLICE-1:0];
                carry_d = slice_sum_s[SLICE];
                if (idx_q == LAST_IDX) begin
                    cout_d      = slice_sum_s[SLICE];
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (slice_sum_s[SLICE-1] != a_q[WIDTH-1]);
`endif
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    idx_d = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                idx_d       = {IDXW{1'b0}};
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any add in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDXW{1'b0}};
            carry_q     <= 1'b0;
            cin_q       <= 1'b0;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            s_q         <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cin_q       <= cin_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Overflow flag register, updated together with cout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_bit32_serial_adder.sv
// Directed and back-to-back random checks for bit32_serial_adder (default WIDTH=32, SLICE=8).
module tb_bit32_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        cout;
    logic        ovf;

    int checks;
    int failures;
    int cyc;

`ifdef SERIAL_ADDER_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    bit32_serial_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter for throughput measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present operands at a negedge and hold in_valid through the accepting edge.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        @(negedge clk);
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Count rising edges after the accept until out_valid; returns latency in edges.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_add(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic cv, input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        send(av, bv, cv);
        in_valid = 1'b0;
        wait_valid(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_s"}, 64'(s), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        @(posedge clk);
        #1;
        chk({tag, "_handoff"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int last_acc;
        logic [32:0] ref_sum;
        checks = 0; failures = 0; cyc = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 32'd0; b = 32'd0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_s", 64'(s), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_add("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_add("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        run_add("t3", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, OVF_ON);
        run_add("t3n", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, OVF_ON);

        // 5 - 3 as 5 + ~3 + 1, with the consumer stalling and stray in_valid pulses
        out_ready = 1'b0;
        send(32'd5, ~32'd3, 1'b1);
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b0;
        wait_valid(lat);
        chk("t4_latency", 64'(lat), 64'd4);
        chk("t4_s", 64'(s), 64'd2);
        chk("t4_cout", 64'(cout), 64'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1);
            @(posedge clk);
            #1;
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_s", 64'(s), 64'd2);
            chk("t4_hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_handoff_valid", 64'(out_valid), 64'd0);
        chk("t4_handoff_in_ready", 64'(in_ready), 64'd1);
        chk("t4_s_kept", 64'(s), 64'd2);

        // Reset in CALC after slice 1 has been written
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_partial_s", 64'(s), 64'h0000_FFFF);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_s", 64'(s), 64'd0);
        chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_add("t5", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        // Back-to-back random: in_valid and out_ready held high
        last_acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(1, 0));
            ref_sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            lat = 0;
            @(negedge clk);
            while (!in_ready && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            if (!in_ready) chk("t6_accept_timeout", 64'(in_ready), 64'd1);
            @(posedge clk);
            if (i > 0) chk("t6_period", 64'(cyc - last_acc), 64'd6);
            last_acc = cyc;
            #1;
            wait_valid(lat);
            chk("t6_s", 64'(s), 64'(ref_sum[31:0]));
            chk("t6_cout", 64'(cout), 64'(ref_sum[32]));
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
